// File: rtl/seq001_scanner.sv
// Scans a RAM address window, runs an overlapping "001" detector on dout[3].
// Optional sticky interrupt (irq / irq_clr) when SEQ001_IRQ_EN is defined.
module seq001_scanner #(
    parameter int ADDR_SIZE = 5,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] start_addr,
    input  logic [ADDR_SIZE-1:0] end_addr,
    output logic                 en_read,
    output logic [ADDR_SIZE-1:0] addr,
    input  logic                 din_bit,
    output logic                 busy,
    output logic                 done,
    output logic                 detect,
    output logic [ADDR_SIZE-1:0] match_addr,
`ifdef SEQ001_IRQ_EN
    output logic [CNT_WIDTH-1:0] match_count,
    output logic                 irq,
    input  logic                 irq_clr
`else
    output logic [CNT_WIDTH-1:0] match_count
`endif
);

    typedef enum logic [1:0] {
        C_IDLE,
        C_ISSUE,
        C_DRAIN,
        C_DONE
    } ctl_t;

    typedef enum logic [1:0] {
        S0,
        S1,
        S2
    } det_t;

    ctl_t ctl_q, ctl_d;
    det_t det_q, det_d;

    logic [ADDR_SIZE-1:0] cur_q, cur_d;
    logic [ADDR_SIZE-1:0] end_q, end_d;
    logic [ADDR_SIZE-1:0] a_q;
    logic                 v_q;
    logic                 accept;
    logic                 hit;
    logic                 detect_q;
    logic [ADDR_SIZE-1:0] match_addr_q;
    logic [CNT_WIDTH-1:0] match_count_q;
    logic                 cnt_full;

    always_comb begin
        ctl_d  = ctl_q;
        cur_d  = cur_q;
        end_d  = end_q;
        accept = 1'b0;
        unique case (ctl_q)
            C_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    cur_d  = start_addr;
                    end_d  = end_addr;
                    ctl_d  = C_ISSUE;
                end
            end
            C_ISSUE: begin
                cur_d = cur_q + 1'b1;
                if (cur_q == end_q)
                    ctl_d = C_DRAIN;
            end
            C_DRAIN: ctl_d = C_DONE;
            C_DONE:  ctl_d = C_IDLE;
            default: ctl_d = C_IDLE;
        endcase
    end

    assign en_read = (ctl_q == C_ISSUE);
    assign addr    = en_read ? cur_q : '0;
    assign busy    = (ctl_q == C_ISSUE) || (ctl_q == C_DRAIN);
    assign done    = (ctl_q == C_DONE);

    // v_q/a_q pair the bit returned this cycle with the address issued last cycle
    always_comb begin
        det_d = det_q;
        hit   = 1'b0;
        if (accept) begin
            det_d = S0;
        end else if (v_q) begin
            unique case (det_q)
                S0: det_d = din_bit ? S0 : S1;
                S1: det_d = din_bit ? S0 : S2;
                S2: begin
                    if (din_bit) begin
                        det_d = S0;
                        hit   = 1'b1;
                    end
                end
                default: det_d = S0;
            endcase
        end
    end

    assign cnt_full = &match_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q         <= C_IDLE;
            det_q         <= S0;
            cur_q         <= '0;
            end_q         <= '0;
            v_q           <= 1'b0;
            a_q           <= '0;
            detect_q      <= 1'b0;
            match_addr_q  <= '0;
            match_count_q <= '0;
        end else begin
            ctl_q    <= ctl_d;
            det_q    <= det_d;
            cur_q    <= cur_d;
            end_q    <= end_d;
            v_q      <= en_read;
            a_q      <= cur_q;
            detect_q <= hit;
            if (hit)
                match_addr_q <= a_q;
            if (accept)
                match_count_q <= '0;
            else if (hit && !cnt_full)
                match_count_q <= match_count_q + 1'b1;
        end
    end

    assign detect      = detect_q;
    assign match_addr  = match_addr_q;
    assign match_count = match_count_q;

`ifdef SEQ001_IRQ_EN
    // Setting in the DONE cycle sees the final count; set beats clear
    always_ff @(posedge clk) begin
        if (rst)
            irq <= 1'b0;
        else if (done && (match_count_q != '0))
            irq <= 1'b1;
        else if (irq_clr)
            irq <= 1'b0;
    end
`endif

endmodule
